// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: operation
// encodings and the modelled latencies of the multi-cycle operations.
`timescale 1ns/1ps
package mult_div_unit_pkg;

    // MDUOp encodings; any code outside this list behaves as MDU_NONE.
    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    // Busy duration after an accepted op. The counter is 4 bits, so these
    // must stay within 1..15.
    localparam logic [3:0] MULT_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES  = 4'd10;

    // True for the four ops that start a multi-cycle operation.
    function automatic logic is_md_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multiply/divide unit beside the ALU. Owns HI/LO. The arithmetic is done
// combinationally at accept time and parked in a pending register; a busy
// counter models the latency and the pending value is committed to HI/LO
// on the edge where the counter falls from 1 to 0.
`timescale 1ns/1ps
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        Req,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUresult
);

    logic [3:0]  cnt_q,     cnt_d;
    logic [31:0] hi_q,      hi_d;
    logic [31:0] lo_q,      lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    // Pending result should be written at commit (cleared for divide by zero).
    logic        pend_wr_q, pend_wr_d;

    logic signed [63:0] a_sx, b_sx, prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] divisor;
    logic signed [31:0] quot_s, rem_s;
    logic        [31:0] quot_u, rem_u;
    logic        [63:0] result;
    logic               is_div;

    assign Busy = (cnt_q != 4'd0);
    assign HI   = hi_q;
    assign LO   = lo_q;

    // Start/MDUresult decode, 64-bit compute and next-state of all registers.
    always_comb begin
        Start     = is_md_op(MDUOp) && !Busy && !Req;
        MDUresult = 32'd0;
        if (MDUOp == MDU_MFHI) begin
            MDUresult = hi_q;
        end else if (MDUOp == MDU_MFLO) begin
            MDUresult = lo_q;
        end

        a_sx    = {{32{A[31]}}, A};
        b_sx    = {{32{B[31]}}, B};
        prod_s  = a_sx * b_sx;
        prod_u  = {32'd0, A} * {32'd0, B};
        // A zero divisor is replaced so the operators never see it; the
        // resulting quotient is discarded at commit anyway.
        divisor = (B == 32'd0) ? 32'd1 : B;
        quot_s  = $signed(A) / $signed(divisor);
        rem_s   = $signed(A) % $signed(divisor);
        quot_u  = A / divisor;
        rem_u   = A % divisor;
        is_div  = (MDUOp == MDU_DIV) || (MDUOp == MDU_DIVU);

        case (MDUOp)
            MDU_MULT:  result = prod_s;
            MDU_MULTU: result = prod_u;
            MDU_DIV:   result = {rem_s, quot_s};
            MDU_DIVU:  result = {rem_u, quot_u};
            default:   result = 64'd0;
        endcase

        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;

        if (Busy) begin
            // In flight: count down, commit on the last cycle. Req does not
            // cancel an op that has already been accepted.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1 && pend_wr_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else if (Start) begin
            pend_hi_d = result[63:32];
            pend_lo_d = result[31:0];
            pend_wr_d = !(is_div && (B == 32'd0));
            cnt_d     = is_div ? DIV_CYCLES : MULT_CYCLES;
        end else if (!Req) begin
            if (MDUOp == MDU_MTHI) begin
                hi_d = A;
            end else if (MDUOp == MDU_MTLO) begin
                lo_d = A;
            end
        end
    end

    // State registers; reset clears everything so no commit can follow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit. Inputs change and outputs are sampled
// 1ns after the rising edge.
`timescale 1ns/1ps
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [3:0]  MDUOp;
    logic        Req;
    logic        Start, Busy;
    logic [31:0] HI, LO, MDUresult;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    mult_div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .B         (B),
        .MDUOp     (MDUOp),
        .Req       (Req),
        .Start     (Start),
        .Busy      (Busy),
        .HI        (HI),
        .LO        (LO),
        .MDUresult (MDUresult)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic req);
        MDUOp = op;
        A     = a;
        B     = b;
        Req   = req;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(MDU_NONE, 32'd0, 32'd0, 1'b0);
        tick();
        tick();
        checks++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: Busy=%b HI=%h LO=%h, required 0/0/0", Busy, HI, LO);
        end
        reset = 1'b0;
        tick();
        $display("reset: Busy=%b HI=%h LO=%h", Busy, HI, LO);
    endtask

    // Each row: op, A, B, busy cycles, expected HI, expected LO.
    task automatic test_arith();
        logic [3:0]  t_op [6] = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIV, MDU_DIVU, MDU_MULT};
        logic [31:0] t_a  [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                  32'h0000_0007, 32'hFFFF_FFFF, 32'h0001_2345};
        logic [31:0] t_b  [6] = '{32'h3, 32'h2, 32'h2, 32'hFFFF_FFFE, 32'hA, 32'h0001_0000};
        int          t_n  [6] = '{5, 5, 10, 10, 10, 5};
        logic [31:0] t_hi [6] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF,
                                  32'h0000_0001, 32'h0000_0005, 32'h0000_0001};
        logic [31:0] t_lo [6] = '{32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'hFFFF_FFFD,
                                  32'hFFFF_FFFD, 32'h1999_9999, 32'h2345_0000};
        for (int k = 0; k < 6; k++) begin
            drive(t_op[k], t_a[k], t_b[k], 1'b0);
            checks++;
            if (Start !== 1'b1) begin
                errors++;
                $display("FAIL arith_start[%0d]: Start=%b, required 1", k, Start);
            end
            tick();
            drive(MDU_NONE, 32'd0, 32'd0, 1'b0);
            for (int i = 0; i < t_n[k]; i++) begin
                checks++;
                if (Busy !== 1'b1 || HI !== exp_hi || LO !== exp_lo) begin
                    errors++;
                    $display("FAIL arith_busy[%0d] cycle %0d: Busy=%b HI=%h LO=%h, required 1/%h/%h",
                             k, i, Busy, HI, LO, exp_hi, exp_lo);
                end
                tick();
            end
            exp_hi = t_hi[k];
            exp_lo = t_lo[k];
            checks++;
            if (Busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
                errors++;
                $display("FAIL arith_result[%0d]: Busy=%b HI=%h LO=%h, required 0/%h/%h",
                         k, Busy, HI, LO, exp_hi, exp_lo);
            end
            $display("arith[%0d]: op=%0d A=%h B=%h -> HI=%h LO=%h", k, t_op[k], t_a[k], t_b[k], HI, LO);
        end
    endtask

    task automatic test_div_by_zero();
        logic [3:0] ops [2] = '{MDU_DIVU, MDU_DIV};
        for (int k = 0; k < 2; k++) begin
            drive(ops[k], 32'd7, 32'd0, 1'b0);
            tick();
            drive(MDU_NONE, 32'd0, 32'd0, 1'b0);
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (Busy !== 1'b1) begin
                    errors++;
                    $display("FAIL divzero_busy[%0d] cycle %0d: Busy=%b, required 1", k, i, Busy);
                end
                tick();
            end
            checks++;
            if (Busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
                errors++;
                $display("FAIL divzero_result[%0d]: Busy=%b HI=%h LO=%h, required 0/%h/%h",
                         k, Busy, HI, LO, exp_hi, exp_lo);
            end
            $display("divzero[%0d]: HI=%h LO=%h", k, HI, LO);
        end
    endtask

    task automatic test_mt_mf();
        drive(MDU_MTHI, 32'h1234_5678, 32'd0, 1'b0);
        tick();
        exp_hi = 32'h1234_5678;
        drive(MDU_MFHI, 32'd0, 32'd0, 1'b0);
        checks++;
        if (MDUresult !== exp_hi) begin
            errors++;
            $display("FAIL mfhi: MDUresult=%h, required %h", MDUresult, exp_hi);
        end
        drive(MDU_MTLO, 32'h9ABC_DEF0, 32'd0, 1'b0);
        tick();
        exp_lo = 32'h9ABC_DEF0;
        drive(MDU_MFLO, 32'd0, 32'd0, 1'b0);
        checks++;
        if (MDUresult !== exp_lo) begin
            errors++;
            $display("FAIL mflo: MDUresult=%h, required %h", MDUresult, exp_lo);
        end
        drive(MDU_MTLO, 32'h1111_1111, 32'd0, 1'b1);
        tick();
        drive(MDU_MFLO, 32'd0, 32'd0, 1'b0);
        checks++;
        if (MDUresult !== exp_lo || HI !== exp_hi) begin
            errors++;
            $display("FAIL mtlo_req: MDUresult=%h HI=%h, required %h/%h", MDUresult, HI, exp_lo, exp_hi);
        end
        drive(MDU_NONE, 32'd0, 32'd0, 1'b0);
        checks++;
        if (MDUresult !== 32'd0) begin
            errors++;
            $display("FAIL mdu_none: MDUresult=%h, required 0", MDUresult);
        end
        drive(4'hF, 32'd5, 32'd3, 1'b0);
        checks++;
        if (MDUresult !== 32'd0 || Start !== 1'b0) begin
            errors++;
            $display("FAIL mdu_undef: MDUresult=%h Start=%b, required 0/0", MDUresult, Start);
        end
        tick();
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL mdu_undef_busy: Busy=%b, required 0", Busy);
        end
        $display("mt_mf: HI=%h LO=%h", HI, LO);
    endtask

    task automatic test_req();
        drive(MDU_MULT, 32'd2, 32'd3, 1'b1);
        checks++;
        if (Start !== 1'b0) begin
            errors++;
            $display("FAIL req_start: Start=%b, required 0", Start);
        end
        tick();
        checks++;
        if (Busy !== 1'b0 || LO !== exp_lo) begin
            errors++;
            $display("FAIL req_squash: Busy=%b LO=%h, required 0/%h", Busy, LO, exp_lo);
        end
        drive(MDU_DIV, 32'd100, 32'd7, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            if (i < 2) drive(MDU_NONE, 32'd0, 32'd0, 1'b0);
            else       drive(MDU_MULT, 32'd9, 32'd9, 1'b1);
            checks++;
            if (Busy !== 1'b1 || Start !== 1'b0) begin
                errors++;
                $display("FAIL req_inflight cycle %0d: Busy=%b Start=%b, required 1/0", i, Busy, Start);
            end
            tick();
        end
        exp_hi = 32'd2;
        exp_lo = 32'd14;
        checks++;
        if (Busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
            errors++;
            $display("FAIL req_commit: Busy=%b HI=%h LO=%h, required 0/%h/%h", Busy, HI, LO, exp_hi, exp_lo);
        end
        drive(MDU_NONE, 32'd0, 32'd0, 1'b0);
        $display("req: HI=%h LO=%h", HI, LO);
    endtask

    task automatic test_back_to_back();
        drive(MDU_MULT, 32'd3, 32'd4, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i < 2) drive(MDU_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
            else       drive(MDU_MULTU, 32'd5, 32'd6, 1'b0);
            checks++;
            if (Busy !== 1'b1 || Start !== 1'b0) begin
                errors++;
                $display("FAIL b2b_busy cycle %0d: Busy=%b Start=%b, required 1/0", i, Busy, Start);
            end
            tick();
        end
        exp_hi = 32'd0;
        exp_lo = 32'd12;
        checks++;
        if (Busy !== 1'b0 || Start !== 1'b1 || HI !== exp_hi || LO !== exp_lo) begin
            errors++;
            $display("FAIL b2b_first: Busy=%b Start=%b HI=%h LO=%h, required 0/1/%h/%h",
                     Busy, Start, HI, LO, exp_hi, exp_lo);
        end
        tick();
        drive(MDU_NONE, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        exp_lo = 32'd30;
        checks++;
        if (Busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
            errors++;
            $display("FAIL b2b_second: Busy=%b HI=%h LO=%h, required 0/%h/%h", Busy, HI, LO, exp_hi, exp_lo);
        end
        $display("back_to_back: HI=%h LO=%h", HI, LO);
    endtask

    task automatic test_reset_mid();
        drive(MDU_DIV, 32'd50, 32'd3, 1'b0);
        tick();
        drive(MDU_NONE, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        #2;
        reset = 1'b1;
        #1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        checks++;
        if (Busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
            errors++;
            $display("FAIL reset_mid: Busy=%b HI=%h LO=%h, required 0/0/0", Busy, HI, LO);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        checks++;
        if (Busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
            errors++;
            $display("FAIL reset_no_commit: Busy=%b HI=%h LO=%h, required 0/0/0", Busy, HI, LO);
        end
        $display("reset_mid: Busy=%b HI=%h LO=%h", Busy, HI, LO);
    endtask

    initial begin
        test_reset();
        test_arith();
        test_div_by_zero();
        test_mt_mf();
        test_req();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
